// File: rtl/riscV_unrn_pkg.sv
// Shared core types: cause codes, trap FSM states and trap bundles.
// Used by trap_controller and trap_priority_enc.
package riscV_unrn_pkg;

  localparam logic [31:0] M_TIMER_INT        = 32'h8000_0007;
  localparam logic [31:0] EXC_INSTR_MISALIGN = 32'd0;
  localparam logic [31:0] EXC_ILLEGAL_INSTR  = 32'd2;
  localparam logic [31:0] EXC_BREAKPOINT     = 32'd3;
  localparam logic [31:0] EXC_LOAD_MISALIGN  = 32'd4;
  localparam logic [31:0] EXC_STORE_MISALIGN = 32'd6;
  localparam logic [31:0] EXC_ECALL_M        = 32'd11;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CAPTURE    = 2'd1,
    TRAP_REDIR = 2'd2,
    MRET_REDIR = 2'd3
  } trap_state_t;

  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] info;
    logic [31:0] pc;
  } trap_req_t;

  typedef struct packed {
    logic        valid;
    logic        is_irq;
    logic        is_mret;
    logic [31:0] cause;
    logic [31:0] info;
  } trap_evt_t;

  function automatic logic [31:0] align4(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_priority_enc.sv
// Picks the single highest-priority trap event at the boundary.
// Pure combinational; mret is the lowest-priority event.
module trap_priority_enc
  import riscV_unrn_pkg::*;
(
  input  logic        irq,
  input  logic        fetch_misalign,
  input  logic        illegal,
  input  logic        ebreak,
  input  logic        ecall,
  input  logic        load_misalign,
  input  logic        store_misalign,
  input  logic        mret,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] mem_addr,
  output trap_evt_t   evt
);

  always_comb begin
    evt = '0;
    priority case (1'b1)
      irq: begin
        evt.valid  = 1'b1;
        evt.is_irq = 1'b1;
        evt.cause  = M_TIMER_INT;
      end
      fetch_misalign: begin
        evt.valid = 1'b1;
        evt.cause = EXC_INSTR_MISALIGN;
        evt.info  = pc;
      end
      illegal: begin
        evt.valid = 1'b1;
        evt.cause = EXC_ILLEGAL_INSTR;
        evt.info  = instr;
      end
      ebreak: begin
        evt.valid = 1'b1;
        evt.cause = EXC_BREAKPOINT;
        evt.info  = pc;
      end
      ecall: begin
        evt.valid = 1'b1;
        evt.cause = EXC_ECALL_M;
      end
      load_misalign: begin
        evt.valid = 1'b1;
        evt.cause = EXC_LOAD_MISALIGN;
        evt.info  = mem_addr;
      end
      store_misalign: begin
        evt.valid = 1'b1;
        evt.cause = EXC_STORE_MISALIGN;
        evt.info  = mem_addr;
      end
      mret: begin
        evt.valid   = 1'b1;
        evt.is_mret = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/trap_controller.sv
// Trap entry / MRET sequencer in front of csrUnit.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets.
module trap_controller
  import riscV_unrn_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IRQ_CAUSE_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] mem_addr_i,
  input  logic        fetch_misalign_i,
  input  logic        illegal_instr_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        load_misalign_i,
  input  logic        store_misalign_i,
  input  logic        mret_i,
  input  logic        irq_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        exc_request_o,
  output logic [31:0] exc_cause_o,
  output logic [31:0] trap_info_o,
  output logic [31:0] trap_pc_o,
  output logic        mret_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);

  trap_state_t state;
  trap_evt_t   evt;
  trap_req_t   req;
  logic        req_irq;
  logic        take;
  logic [31:0] vec_off;
  logic [31:0] target;
  logic        unused_bits;

  trap_priority_enc u_prio (
    .irq            (irq_i),
    .fetch_misalign (fetch_misalign_i),
    .illegal        (illegal_instr_i),
    .ebreak         (ebreak_i),
    .ecall          (ecall_i),
    .load_misalign  (load_misalign_i),
    .store_misalign (store_misalign_i),
    .mret           (mret_i),
    .pc             (pc_i),
    .instr          (instr_i),
    .mem_addr       (mem_addr_i),
    .evt            (evt)
  );

  assign take    = rst && (state == IDLE)
                 && instr_valid_i && evt.valid;
  assign flush_o = take;

  assign vec_off =
    32'(req.cause[IRQ_CAUSE_W-1:0]) << 2;

  always_comb begin
    target = align4(mtvec_i);
`ifdef TRAP_VECTORED_EN
    if (req_irq && (mtvec_i[1:0] == 2'b01))
      target = align4(mtvec_i) + vec_off;
`endif
  end

  // Mode bits are only consulted in the vectored build.
  assign unused_bits = ^{mtvec_i[1:0], mepc_i[1:0], vec_off};

  assign exc_cause_o = req.cause;
  assign trap_info_o = req.info;
  assign trap_pc_o   = req.pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      req           <= '0;
      req_irq       <= 1'b0;
      exc_request_o <= 1'b0;
      mret_o        <= 1'b0;
      stall_o       <= 1'b0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= RESET_PC;
    end else begin
      exc_request_o <= 1'b0;
      mret_o        <= 1'b0;
      redirect_o    <= 1'b0;
      unique case (state)
        IDLE: begin
          stall_o <= 1'b0;
          if (take) begin
            stall_o <= 1'b1;
            if (evt.is_mret) begin
              state         <= MRET_REDIR;
              redirect_o    <= 1'b1;
              redirect_pc_o <= align4(mepc_i);
              mret_o        <= 1'b1;
            end else begin
              state         <= CAPTURE;
              exc_request_o <= 1'b1;
              req.cause     <= evt.cause;
              req.info      <= evt.info;
              req.pc        <= pc_i;
              req_irq       <= evt.is_irq;
            end
          end
        end
        CAPTURE: begin
          state         <= TRAP_REDIR;
          stall_o       <= 1'b1;
          redirect_o    <= 1'b1;
          redirect_pc_o <= target;
        end
        TRAP_REDIR: begin
          state   <= IDLE;
          stall_o <= 1'b0;
        end
        MRET_REDIR: begin
          state   <= IDLE;
          stall_o <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          stall_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller.
// Expected values are hand-derived per scenario.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid_i;
  logic [31:0] pc_i, instr_i, mem_addr_i;
  logic        fetch_misalign_i, illegal_instr_i;
  logic        ecall_i, ebreak_i;
  logic        load_misalign_i, store_misalign_i;
  logic        mret_i, irq_i;
  logic [31:0] mtvec_i, mepc_i;
  logic        exc_request_o;
  logic [31:0] exc_cause_o, trap_info_o, trap_pc_o;
  logic        mret_o, stall_o, flush_o, redirect_o;
  logic [31:0] redirect_pc_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  trap_controller dut (
    .clk              (clk),
    .rst              (rst),
    .instr_valid_i    (instr_valid_i),
    .pc_i             (pc_i),
    .instr_i          (instr_i),
    .mem_addr_i       (mem_addr_i),
    .fetch_misalign_i (fetch_misalign_i),
    .illegal_instr_i  (illegal_instr_i),
    .ecall_i          (ecall_i),
    .ebreak_i         (ebreak_i),
    .load_misalign_i  (load_misalign_i),
    .store_misalign_i (store_misalign_i),
    .mret_i           (mret_i),
    .irq_i            (irq_i),
    .mtvec_i          (mtvec_i),
    .mepc_i           (mepc_i),
    .exc_request_o    (exc_request_o),
    .exc_cause_o      (exc_cause_o),
    .trap_info_o      (trap_info_o),
    .trap_pc_o        (trap_pc_o),
    .mret_o           (mret_o),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .redirect_o       (redirect_o),
    .redirect_pc_o    (redirect_pc_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // f = {irq, fmis, ill, ebrk, ecall, lmis, smis, mret}
  task automatic drive(input logic [7:0] f,
                       input logic v,
                       input logic [31:0] pc,
                       input logic [31:0] ins,
                       input logic [31:0] addr);
    instr_valid_i    = v;
    irq_i            = f[7];
    fetch_misalign_i = f[6];
    illegal_instr_i  = f[5];
    ebreak_i         = f[4];
    ecall_i          = f[3];
    load_misalign_i  = f[2];
    store_misalign_i = f[1];
    mret_i           = f[0];
    pc_i             = pc;
    instr_i          = ins;
    mem_addr_i       = addr;
  endtask

  task automatic quiet();
    drive(8'h00, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic trap_seq(input string nm,
                          input logic [7:0] f,
                          input logic [31:0] pc,
                          input logic [31:0] ins,
                          input logic [31:0] addr,
                          input logic [31:0] e_cause,
                          input logic [31:0] e_info,
                          input logic [31:0] e_tgt);
    @(negedge clk);
    drive(f, 1'b1, pc, ins, addr);
    #1;
    chk({nm, ".T.flush"}, 32'(flush_o), 32'd1);
    chk({nm, ".T.stall"}, 32'(stall_o), 32'd0);
    @(negedge clk);
    quiet();
    #1;
    chk({nm, ".T1.req"}, 32'(exc_request_o), 32'd1);
    chk({nm, ".T1.cause"}, exc_cause_o, e_cause);
    chk({nm, ".T1.info"}, trap_info_o, e_info);
    chk({nm, ".T1.pc"}, trap_pc_o, pc);
    chk({nm, ".T1.stall"}, 32'(stall_o), 32'd1);
    chk({nm, ".T1.mret"}, 32'(mret_o), 32'd0);
    chk({nm, ".T1.redir"}, 32'(redirect_o), 32'd0);
    @(negedge clk);
    #1;
    chk({nm, ".T2.req"}, 32'(exc_request_o), 32'd0);
    chk({nm, ".T2.redir"}, 32'(redirect_o), 32'd1);
    chk({nm, ".T2.rpc"}, redirect_pc_o, e_tgt);
    chk({nm, ".T2.stall"}, 32'(stall_o), 32'd1);
    chk({nm, ".T2.mret"}, 32'(mret_o), 32'd0);
    @(negedge clk);
    #1;
    chk({nm, ".T3.redir"}, 32'(redirect_o), 32'd0);
    chk({nm, ".T3.stall"}, 32'(stall_o), 32'd0);
    chk({nm, ".T3.hold"}, exc_cause_o, e_cause);
  endtask

  logic [31:0] irq_tgt;

  initial begin
    rst = 1'b0;
    quiet();
    mtvec_i = 32'h0000_0200;
    mepc_i  = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.req", 32'(exc_request_o), 32'd0);
    chk("rst.stall", 32'(stall_o), 32'd0);
    chk("rst.flush", 32'(flush_o), 32'd0);
    chk("rst.redir", 32'(redirect_o), 32'd0);
    chk("rst.mret", 32'(mret_o), 32'd0);
    chk("rst.cause", exc_cause_o, 32'h0);
    chk("rst.rpc", redirect_pc_o, 32'h0);
    rst = 1'b1;

    trap_seq("ill", 8'h20, 32'h100, 32'hFFFF_FFFF,
             32'h0, 32'd2, 32'hFFFF_FFFF, 32'h200);
    trap_seq("ecall_lmis", 8'h0C, 32'h104, 32'h0,
             32'h1003, 32'd11, 32'h0, 32'h200);
    trap_seq("fmis_ill", 8'h60, 32'h10A, 32'h1234,
             32'h0, 32'd0, 32'h10A, 32'h200);
    trap_seq("ebrk_smis", 8'h12, 32'h110, 32'h0,
             32'h2002, 32'd3, 32'h110, 32'h200);
    trap_seq("smis", 8'h02, 32'h114, 32'h0,
             32'h3001, 32'd6, 32'h3001, 32'h200);
    trap_seq("lmis", 8'h04, 32'h118, 32'h0,
             32'h3002, 32'd4, 32'h3002, 32'h200);

    mtvec_i = 32'h0000_0201;
`ifdef TRAP_VECTORED_EN
    irq_tgt = 32'h0000_021C;
`else
    irq_tgt = 32'h0000_0200;
`endif
    trap_seq("irq_mret", 8'h81, 32'h40, 32'h0,
             32'h0, 32'h8000_0007, 32'h0, irq_tgt);
    // Exceptions always use the base even in vectored mode.
    trap_seq("ill_vec", 8'h20, 32'h44, 32'hDEAD_BEEF,
             32'h0, 32'd2, 32'hDEAD_BEEF, 32'h200);
    mtvec_i = 32'h0000_0200;

    mepc_i = 32'h0000_0087;
    @(negedge clk);
    drive(8'h01, 1'b1, 32'h50, 32'h0, 32'h0);
    #1;
    chk("mret.T.flush", 32'(flush_o), 32'd1);
    @(negedge clk);
    quiet();
    #1;
    chk("mret.T1.redir", 32'(redirect_o), 32'd1);
    chk("mret.T1.rpc", redirect_pc_o, 32'h84);
    chk("mret.T1.mret", 32'(mret_o), 32'd1);
    chk("mret.T1.stall", 32'(stall_o), 32'd1);
    chk("mret.T1.req", 32'(exc_request_o), 32'd0);
    @(negedge clk);
    #1;
    chk("mret.T2.mret", 32'(mret_o), 32'd0);
    chk("mret.T2.stall", 32'(stall_o), 32'd0);
    chk("mret.T2.redir", 32'(redirect_o), 32'd0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(8'h80, 1'b0, 32'h300, 32'h0, 32'h0);
      #1;
      chk("irqwait.flush", 32'(flush_o), 32'd0);
      chk("irqwait.req", 32'(exc_request_o), 32'd0);
      chk("irqwait.stall", 32'(stall_o), 32'd0);
    end
    trap_seq("irqtake", 8'h80, 32'h300, 32'h0,
             32'h0, 32'h8000_0007, 32'h0, 32'h200);

    @(negedge clk);
    drive(8'h20, 1'b1, 32'h120, 32'h0BAD_0BAD, 32'h0);
    @(negedge clk);
    quiet();
    rst = 1'b0;
    #1;
    chk("rstmid.pre.req", 32'(exc_request_o), 32'd1);
    @(negedge clk);
    #1;
    chk("rstmid.req", 32'(exc_request_o), 32'd0);
    chk("rstmid.rpc", redirect_pc_o, 32'h0);
    chk("rstmid.stall", 32'(stall_o), 32'd0);
    chk("rstmid.redir", 32'(redirect_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rstmid.idle.redir", 32'(redirect_o), 32'd0);
    chk("rstmid.idle.stall", 32'(stall_o), 32'd0);
    trap_seq("post_rst", 8'h08, 32'h130, 32'h0,
             32'h0, 32'd11, 32'h0, 32'h200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
